// File: rtl/fpu_cmp_issue.sv
// Issue stage for the feq/flt/fle compare units. Results come back in order
// through a FIFO; credits keep that FIFO from overflowing.
module fpu_cmp_issue #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            sys_clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     cu_x1,
  output logic [31:0]     cu_x2,
  output logic [2:0]      cu_valid,
  input  logic [31:0]     feq_y,
  input  logic [31:0]     flt_y,
  input  logic [31:0]     fle_y,
  input  logic [2:0]      cu_out_valid,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [TAGW-1:0] wb_tag,
  output logic            wb_err,
  output logic            busy,
  output logic            proto_err
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CRW  = $clog2(DEPTH + LAT + 2) + 1;

  typedef struct packed {
    logic            vld;
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
  } stg_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            res;
    logic            err;
  } ent_t;

  stg_t             iss_q, iss_d;
  logic [31:0]      x1_q, x1_d, x2_q, x2_d;
  stg_t [LAT-1:0]   tp_q, tp_d;
  ent_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             proto_q, proto_d;

  logic           accept, push, pop, hit, miss, spurious, unit_y, tp_any;
  logic [2:0]     exp_mask;
  stg_t           exp_e;
  ent_t           push_ent, head;
  logic [CRW-1:0] credit;
  logic           unused_y;

  function automatic logic [2:0] onehot(input logic [1:0] op);
    case (op)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count everything that will eventually land in the FIFO.
  always_comb begin
    credit = CRW'(count_q) + CRW'(iss_q.vld);
    tp_any = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      credit = credit + CRW'(tp_q[i].vld);
      tp_any = tp_any | tp_q[i].vld;
    end
  end

  assign req_ready = credit < CRW'(DEPTH);
  assign wb_valid  = (count_q != '0);

  always_comb begin
    accept    = req_valid & req_ready;
    iss_d.vld = accept;
    iss_d.op  = req_op;
    iss_d.tag = req_tag;
    x1_d      = accept ? req_x1 : x1_q;
    x2_d      = accept ? req_x2 : x2_q;

    tp_d    = tp_q;
    tp_d[0] = iss_q;
    for (int i = 1; i < LAT; i++) tp_d[i] = tp_q[i-1];

    // The last tag stage names the one unit allowed to answer this cycle.
    exp_e    = tp_q[LAT-1];
    exp_mask = exp_e.vld ? onehot(exp_e.op) : 3'b000;
    hit      = |(exp_mask & cu_out_valid);
    miss     = (|exp_mask) & ~hit;
    spurious = |(cu_out_valid & ~exp_mask);
    case (exp_e.op)
      2'd0:    unit_y = feq_y[0];
      2'd1:    unit_y = flt_y[0];
      2'd2:    unit_y = fle_y[0];
      default: unit_y = 1'b0;
    endcase
    push         = exp_e.vld;
    push_ent.tag = exp_e.tag;
    push_ent.res = hit & unit_y;
    push_ent.err = ~hit;
    proto_d      = proto_q | miss | spurious;

    head   = fifo_q[rd_ptr_q];
    pop    = wb_valid & wb_ready;
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = push_ent;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      iss_q    <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      tp_q     <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      proto_q  <= 1'b0;
    end else begin
      iss_q    <= iss_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      tp_q     <= tp_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      proto_q  <= proto_d;
    end
  end

  assign cu_x1     = x1_q;
  assign cu_x2     = x2_q;
  assign cu_valid  = iss_q.vld ? onehot(iss_q.op) : 3'b000;
  assign wb_data   = {31'b0, wb_valid & head.res};
  assign wb_tag    = wb_valid ? head.tag : '0;
  assign wb_err    = wb_valid & head.err;
  assign busy      = iss_q.vld | tp_any | wb_valid;
  assign proto_err = proto_q;

  // Units return all-ones or zero; only bit 0 carries the answer.
  assign unused_y = ^{feq_y[31:1], flt_y[31:1], fle_y[31:1]};

endmodule
